// File: rtl/fdsti_sched_pkg.sv
// ---------------------------------------------------------------------------
// fdsti_sched_pkg
// Shared types and default widths for the FDSSI->FDSTI reorder scheduler.
//   sched_state_t : scheduler FSM state (IDLE / RUN / DONE)
//   *_DEF         : default parameter values used by the scheduler modules
//   N             : default source count (2**SRC_W_DEF)
// ---------------------------------------------------------------------------
package fdsti_sched_pkg;

   localparam int unsigned SRC_W_DEF   = 2;
   localparam int unsigned FDSTI_W_DEF = 28;
   localparam int unsigned AWIDTH_DEF  = 32;
   localparam int unsigned CNT_W_DEF   = 16;
   localparam int unsigned N           = 2**SRC_W_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

endpackage

// File: rtl/fdsti_min_tree.sv
// ---------------------------------------------------------------------------
// fdsti_min_tree
// Combinational minimum search over 2**SRC_W {valid, fdsti, idx} tuples,
// built as a pairwise reduction tree SRC_W levels deep.
//   i_valid     : per-source valid
//   i_fdsti     : per-source FDSTI, source k at [k*FDSTI_W +: FDSTI_W]
//   o_any_valid : at least one source is valid
//   o_win_idx   : index of the valid source with the smallest FDSTI;
//                 ties resolve to the lower index
// ---------------------------------------------------------------------------
module fdsti_min_tree
   import fdsti_sched_pkg::*;
#(
   parameter int unsigned SRC_W   = SRC_W_DEF,
   parameter int unsigned FDSTI_W = FDSTI_W_DEF
) (
   input  logic [2**SRC_W-1:0]           i_valid,
   input  logic [(2**SRC_W)*FDSTI_W-1:0] i_fdsti,
   output logic                          o_any_valid,
   output logic [SRC_W-1:0]              o_win_idx
);

   localparam int unsigned N_SRC = 2**SRC_W;

   // Heap layout: node n combines children 2n (lower indices) and 2n+1.
   // Leaves sit at N_SRC..2*N_SRC-1, the root is node 1.
   logic               w_nd_valid [2*N_SRC];
   logic [FDSTI_W-1:0] w_nd_fdsti [2*N_SRC];
   logic [SRC_W-1:0]   w_nd_idx   [2*N_SRC];

   always_comb begin
      for (int unsigned n = 0; n < 2*N_SRC; n++) begin
         w_nd_valid[n] = 1'b0;
         w_nd_fdsti[n] = '0;
         w_nd_idx[n]   = '0;
      end
      for (int unsigned k = 0; k < N_SRC; k++) begin
         w_nd_valid[N_SRC+k] = i_valid[k];
         w_nd_fdsti[N_SRC+k] = i_fdsti[k*FDSTI_W +: FDSTI_W];
         w_nd_idx[N_SRC+k]   = SRC_W'(k);
      end
      for (int unsigned n = N_SRC-1; n >= 1; n--) begin
         // Right child wins only when strictly smaller, so ties keep the left.
         if (w_nd_valid[2*n+1] &&
             (!w_nd_valid[2*n] || (w_nd_fdsti[2*n+1] < w_nd_fdsti[2*n]))) begin
            w_nd_valid[n] = 1'b1;
            w_nd_fdsti[n] = w_nd_fdsti[2*n+1];
            w_nd_idx[n]   = w_nd_idx[2*n+1];
         end else begin
            w_nd_valid[n] = w_nd_valid[2*n];
            w_nd_fdsti[n] = w_nd_fdsti[2*n];
            w_nd_idx[n]   = w_nd_idx[2*n];
         end
      end
      o_any_valid = w_nd_valid[1];
      o_win_idx   = w_nd_idx[1];
   end

endmodule

// File: rtl/fdsti_min_sched.sv
// ---------------------------------------------------------------------------
// fdsti_min_sched
// Merges 2**SRC_W per-FDSSI FIFOs (each sorted by FDSTI) into one stream
// ordered by FDSTI, once all sources have been written (in_finish).
//   clk, rst_n  : clock, synchronous active-low reset
//   in_finish   : pulse, all sources fully written; starts the merge
//   s_valid     : per-source head valid
//   s_ready     : per-source pop (one-hot or zero)
//   s_fdsti     : per-source head FDSTI
//   s_addr      : per-source head {s_addr, e_addr}
//   m_valid/m_ready : registered output handshake
//   m_fdsti, m_fdssi, m_addr : selected FDSTI, source index, {s_addr,e_addr}
//   busy        : merging in progress
//   done        : sticky, all sources drained and last word accepted
//   order_err   : sticky, an accepted FDSTI was below its predecessor
//   emit_cnt    : accepted output words (wraps)
// ---------------------------------------------------------------------------
module fdsti_min_sched
   import fdsti_sched_pkg::*;
#(
   parameter int unsigned SRC_W   = SRC_W_DEF,
   parameter int unsigned FDSTI_W = FDSTI_W_DEF,
   parameter int unsigned AWIDTH  = AWIDTH_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_finish,
   input  logic [2**SRC_W-1:0]               s_valid,
   output logic [2**SRC_W-1:0]               s_ready,
   input  logic [(2**SRC_W)*FDSTI_W-1:0]     s_fdsti,
   input  logic [(2**SRC_W)*2*AWIDTH-1:0]    s_addr,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [FDSTI_W-1:0]                m_fdsti,
   output logic [SRC_W-1:0]                  m_fdssi,
   output logic [2*AWIDTH-1:0]               m_addr,
   output logic                              busy,
   output logic                              done,
   output logic                              order_err,
   output logic [CNT_W-1:0]                  emit_cnt
);

   localparam int unsigned N_SRC = 2**SRC_W;
   localparam int unsigned PW    = 2*AWIDTH;

   sched_state_t       r_state;
   logic               r_m_valid;
   logic [FDSTI_W-1:0] r_m_fdsti;
   logic [SRC_W-1:0]   r_m_fdssi;
   logic [PW-1:0]      r_m_addr;
   logic               r_done;
   logic               r_order_err;
   logic [CNT_W-1:0]   r_emit_cnt;
   logic [FDSTI_W-1:0] r_last_fdsti;
   logic               r_first;

   logic               w_any_valid;
   logic [SRC_W-1:0]   w_win_idx;
   logic [N_SRC-1:0]   w_grant;
   logic [FDSTI_W-1:0] w_sel_fdsti;
   logic [PW-1:0]      w_sel_addr;
   logic               w_accept;
   logic               w_load;

   fdsti_min_tree #(
      .SRC_W   (SRC_W),
      .FDSTI_W (FDSTI_W)
   ) u_min_tree (
      .i_valid     (s_valid),
      .i_fdsti     (s_fdsti),
      .o_any_valid (w_any_valid),
      .o_win_idx   (w_win_idx)
   );

   always_comb begin
      w_grant            = '0;
      w_grant[w_win_idx] = 1'b1;
      w_sel_fdsti        = s_fdsti[w_win_idx*FDSTI_W +: FDSTI_W];
      w_sel_addr         = s_addr[w_win_idx*PW +: PW];
      w_accept           = r_m_valid & m_ready;
      // rst_n gates the pop so a source is never consumed in the cycle the
      // output register is being discarded.
      w_load             = rst_n & (r_state == RUN) & w_any_valid &
                           (~r_m_valid | m_ready);
   end

   assign s_ready   = w_load ? w_grant : '0;
   assign m_valid   = r_m_valid;
   assign m_fdsti   = r_m_fdsti;
   assign m_fdssi   = r_m_fdssi;
   assign m_addr    = r_m_addr;
   assign busy      = (r_state == RUN);
   assign done      = r_done;
   assign order_err = r_order_err;
   assign emit_cnt  = r_emit_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_m_valid    <= 1'b0;
         r_m_fdsti    <= '0;
         r_m_fdssi    <= '0;
         r_m_addr     <= '0;
         r_done       <= 1'b0;
         r_order_err  <= 1'b0;
         r_emit_cnt   <= '0;
         r_last_fdsti <= '0;
         r_first      <= 1'b1;
      end else begin
         case (r_state)
            IDLE: if (in_finish) r_state <= RUN;
            RUN: begin
               // Finish only once the output register is empty or emptying.
               if (!w_any_valid && (!r_m_valid || m_ready)) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE:    r_state <= DONE;
            default: r_state <= IDLE;
         endcase

         if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_fdsti <= w_sel_fdsti;
            r_m_fdssi <= w_win_idx;
            r_m_addr  <= w_sel_addr;
         end else if (w_accept) begin
            r_m_valid <= 1'b0;
         end

         if (w_accept) begin
            r_emit_cnt <= r_emit_cnt + CNT_W'(1);
            if (!r_first && (r_m_fdsti < r_last_fdsti)) r_order_err <= 1'b1;
            r_last_fdsti <= r_m_fdsti;
            r_first      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fdsti_min_sched.sv
module tb_fdsti_min_sched;

   localparam int SRC_W = 2;
   localparam int FW    = 28;
   localparam int AW    = 32;
   localparam int CW    = 16;
   localparam int N     = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_finish;
   logic [N-1:0]      s_valid;
   logic [N-1:0]      s_ready;
   logic [N*FW-1:0]   s_fdsti;
   logic [N*2*AW-1:0] s_addr;
   logic              m_valid;
   logic              m_ready;
   logic [FW-1:0]     m_fdsti;
   logic [SRC_W-1:0]  m_fdssi;
   logic [2*AW-1:0]   m_addr;
   logic              busy;
   logic              done;
   logic              order_err;
   logic [CW-1:0]     emit_cnt;

   always #5 clk = ~clk;

   fdsti_min_sched #(
      .SRC_W   (SRC_W),
      .FDSTI_W (FW),
      .AWIDTH  (AW),
      .CNT_W   (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_finish (in_finish),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_fdsti   (s_fdsti),
      .s_addr    (s_addr),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_fdsti   (m_fdsti),
      .m_fdssi   (m_fdssi),
      .m_addr    (m_addr),
      .busy      (busy),
      .done      (done),
      .order_err (order_err),
      .emit_cnt  (emit_cnt)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Source FIFO model
   logic [FW-1:0] src_f [N][8];
   int            src_len [N];
   int            src_rd  [N];

   // Observed accepted outputs
   logic [FW-1:0]    obs_f [16];
   logic [SRC_W-1:0] obs_i [16];
   logic [2*AW-1:0]  obs_a [16];
   int               n_obs;

   logic [N-1:0] last_rdy;
   logic         last_mvalid;
   logic         done_at_acc;
   logic         oerr_at_acc;

   function automatic logic [63:0] addr_of(input int k, input int j);
      return (64'(k + 1) << 32) | 64'h00A0_0000 | 64'(j);
   endfunction

   task automatic clear_src();
      for (int k = 0; k < N; k++) begin
         src_len[k] = 0;
         src_rd[k]  = 0;
      end
      n_obs = 0;
      for (int j = 0; j < 16; j++) begin
         obs_f[j] = '1;
         obs_i[j] = '1;
         obs_a[j] = '1;
      end
   endtask

   task automatic push(input int k, input logic [FW-1:0] f);
      src_f[k][src_len[k]] = f;
      src_len[k]++;
   endtask

   task automatic drive_src();
      for (int k = 0; k < N; k++) begin
         if (src_rd[k] < src_len[k]) begin
            s_valid[k]              = 1'b1;
            s_fdsti[k*FW +: FW]     = src_f[k][src_rd[k]];
            s_addr[k*2*AW +: 2*AW]  = addr_of(k, src_rd[k]);
         end else begin
            s_valid[k]              = 1'b0;
            s_fdsti[k*FW +: FW]     = '0;
            s_addr[k*2*AW +: 2*AW]  = '0;
         end
      end
   endtask

   // One clock: drive sources, sample before the edge, pop and record after it.
   task automatic step();
      logic             acc;
      logic [FW-1:0]    af;
      logic [SRC_W-1:0] ai;
      logic [2*AW-1:0]  aa;
      drive_src();
      #1;
      last_rdy    = s_ready;
      last_mvalid = m_valid;
      acc         = m_valid & m_ready;
      af          = m_fdsti;
      ai          = m_fdssi;
      aa          = m_addr;
      if (acc) begin
         done_at_acc = done;
         oerr_at_acc = order_err;
      end
      @(posedge clk);
      for (int k = 0; k < N; k++)
         if (last_rdy[k] && src_rd[k] < src_len[k]) src_rd[k]++;
      if (acc && n_obs < 16) begin
         obs_f[n_obs] = af;
         obs_i[n_obs] = ai;
         obs_a[n_obs] = aa;
         n_obs++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_finish = 1'b0;
      m_ready   = 1'b0;
      clear_src();
      step();
      rst_n = 1'b1;
      n_obs = 0;
   endtask

   task automatic finish_pulse();
      in_finish = 1'b1;
      step();
      in_finish = 1'b0;
   endtask

   task automatic run_until_done(input string name, input int budget);
      int c = 0;
      while (done !== 1'b1 && c < budget) begin
         step();
         c++;
      end
      chk({name, "_done_in_budget"}, 64'(done), 64'd1);
   endtask

   task automatic chk_obs(input string name, input int j, input logic [FW-1:0] f,
                          input int k, input int e);
      chk($sformatf("%s_out%0d_fdsti", name, j), 64'(obs_f[j]), 64'(f));
      chk($sformatf("%s_out%0d_fdssi", name, j), 64'(obs_i[j]), 64'(k));
      chk($sformatf("%s_out%0d_addr",  name, j), obs_a[j], addr_of(k, e));
   endtask

   // Selection table
   typedef struct packed {
      logic [3:0]    v;
      logic [FW-1:0] f3, f2, f1, f0;
      logic [1:0]    idx;
   } sel_vec_t;

   sel_vec_t vecs [10];

   function automatic logic [FW-1:0] vec_f(input sel_vec_t t, input int k);
      case (k)
         0:       return t.f0;
         1:       return t.f1;
         2:       return t.f2;
         default: return t.f3;
      endcase
   endfunction

   task automatic drive_vec(input sel_vec_t t);
      s_valid = t.v;
      s_fdsti = {t.f3, t.f2, t.f1, t.f0};
      s_addr  = {addr_of(3, 0), addr_of(2, 0), addr_of(1, 0), addr_of(0, 0)};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{4'b1111, 28'd40, 28'd30, 28'd20, 28'd10, 2'd0};
      vecs[1] = '{4'b1111, 28'd10, 28'd20, 28'd30, 28'd40, 2'd3};
      vecs[2] = '{4'b1110, 28'd60, 28'd50, 28'd50, 28'd1, 2'd1};
      vecs[3] = '{4'b1000, 28'hFFFFFFF, 28'd0, 28'd0, 28'd0, 2'd3};
      vecs[4] = '{4'b0101, 28'd0, 28'd7, 28'd0, 28'd7, 2'd0};
      vecs[5] = '{4'b1010, 28'hFFFFFFE, 28'd0, 28'hFFFFFFF, 28'd0, 2'd3};
      vecs[6] = '{4'b0100, 28'd0, 28'd0, 28'd0, 28'd0, 2'd2};
      vecs[7] = '{4'b1111, 28'd100, 28'd100, 28'd100, 28'd100, 2'd0};
      vecs[8] = '{4'b0110, 28'd0, 28'h7FFFFFF, 28'h8000000, 28'd0, 2'd2};
      vecs[9] = '{4'b1100, 28'd5, 28'd5, 28'd9, 28'd1, 2'd2};

      rst_n     = 1'b0;
      in_finish = 1'b0;
      m_ready   = 1'b0;
      s_valid   = '0;
      s_fdsti   = '0;
      s_addr    = '0;
      @(negedge clk);

      // Reset state
      do_reset();
      chk("rst_m_valid",   64'(m_valid),   64'd0);
      chk("rst_m_fdsti",   64'(m_fdsti),   64'd0);
      chk("rst_m_fdssi",   64'(m_fdssi),   64'd0);
      chk("rst_m_addr",    m_addr,         64'd0);
      chk("rst_s_ready",   64'(s_ready),   64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_done",      64'(done),      64'd0);
      chk("rst_order_err", 64'(order_err), 64'd0);
      chk("rst_emit_cnt",  64'(emit_cnt),  64'd0);

      // Selection table: one load per cycle with m_ready held high
      m_ready = 1'b1;
      drive_vec(vecs[0]);
      in_finish = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_finish = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive_vec(vecs[i]);
         #1;
         chk($sformatf("sel%0d_s_ready", i), 64'(s_ready), 64'(4'b0001 << vecs[i].idx));
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("sel%0d_m_valid", i), 64'(m_valid), 64'd1);
         chk($sformatf("sel%0d_m_fdsti", i), 64'(m_fdsti), 64'(vec_f(vecs[i], int'(vecs[i].idx))));
         chk($sformatf("sel%0d_m_fdssi", i), 64'(m_fdssi), 64'(vecs[i].idx));
         chk($sformatf("sel%0d_m_addr",  i), m_addr, addr_of(int'(vecs[i].idx), 0));
      end

      // Merge of four sources, with sources visible long before in_finish
      do_reset();
      push(0, 28'd5); push(0, 28'd9); push(1, 28'd3); push(2, 28'd5);
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("pre%0d_s_ready", i), 64'(last_rdy), 64'd0);
         chk($sformatf("pre%0d_m_valid", i), 64'(last_mvalid), 64'd0);
      end
      finish_pulse();
      chk("t1_finish_cycle_s_ready", 64'(last_rdy), 64'd0);
      step();
      chk("t1_first_pop", 64'(last_rdy), 64'b0010);
      run_until_done("t1", 30);
      chk("t1_count", 64'(n_obs), 64'd4);
      chk_obs("t1", 0, 28'd3, 1, 0);
      chk_obs("t1", 1, 28'd5, 0, 0);
      chk_obs("t1", 2, 28'd5, 2, 0);
      chk_obs("t1", 3, 28'd9, 0, 1);
      chk("t1_done_low_at_last_accept", 64'(done_at_acc), 64'd0);
      chk("t1_emit_cnt",  64'(emit_cnt),  64'd4);
      chk("t1_order_err", 64'(order_err), 64'd0);
      chk("t1_busy",      64'(busy),      64'd0);

      // Backpressure
      do_reset();
      push(0, 28'd1); push(0, 28'd6); push(1, 28'd2); push(3, 28'd4);
      finish_pulse();
      step();
      chk("t2_first_pop", 64'(last_rdy), 64'b0001);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("t2_stall%0d_s_ready", i), 64'(last_rdy), 64'd0);
         chk($sformatf("t2_stall%0d_m_valid", i), 64'(m_valid),  64'd1);
         chk($sformatf("t2_stall%0d_m_fdsti", i), 64'(m_fdsti),  64'd1);
         chk($sformatf("t2_stall%0d_m_fdssi", i), 64'(m_fdssi),  64'd0);
         chk($sformatf("t2_stall%0d_m_addr",  i), m_addr,        addr_of(0, 0));
      end
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("t2_count_after_4_cycles", 64'(n_obs), 64'd4);
      chk_obs("t2", 0, 28'd1, 0, 0);
      chk_obs("t2", 1, 28'd2, 1, 0);
      chk_obs("t2", 2, 28'd4, 3, 0);
      chk_obs("t2", 3, 28'd6, 0, 1);
      chk("t2_done",     64'(done),     64'd1);
      chk("t2_emit_cnt", 64'(emit_cnt), 64'd4);

      // in_finish with every source empty
      do_reset();
      m_ready = 1'b1;
      finish_pulse();
      chk("t4_busy_1",  64'(busy), 64'd1);
      chk("t4_done_0",  64'(done), 64'd0);
      step();
      chk("t4_busy_2",  64'(busy),     64'd0);
      chk("t4_done_2",  64'(done),     64'd1);
      chk("t4_emit",    64'(emit_cnt), 64'd0);
      chk("t4_m_valid", 64'(m_valid),  64'd0);

      // Unsorted source produces an order error on the second accept
      do_reset();
      push(0, 28'd8); push(0, 28'd4);
      m_ready = 1'b1;
      finish_pulse();
      run_until_done("t5", 20);
      chk("t5_count", 64'(n_obs), 64'd2);
      chk_obs("t5", 0, 28'd8, 0, 0);
      chk_obs("t5", 1, 28'd4, 0, 1);
      chk("t5_oerr_before_2nd_accept", 64'(oerr_at_acc), 64'd0);
      chk("t5_order_err", 64'(order_err), 64'd1);
      chk("t5_emit_cnt",  64'(emit_cnt),  64'd2);

      // Reset in the middle of RUN, then restart
      do_reset();
      push(0, 28'd1); push(0, 28'd2); push(0, 28'd3); push(0, 28'd7);
      m_ready = 1'b1;
      finish_pulse();
      step(); step(); step();
      chk("t6_pre_count",  64'(n_obs),    64'd2);
      chk("t6_pre_emit",   64'(emit_cnt), 64'd2);
      chk("t6_pre_mvalid", 64'(m_valid),  64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t6_rst_cycle_s_ready", 64'(last_rdy),  64'd0);
      chk("t6_m_valid",           64'(m_valid),   64'd0);
      chk("t6_busy",              64'(busy),      64'd0);
      chk("t6_done",              64'(done),      64'd0);
      chk("t6_emit_cnt",          64'(emit_cnt),  64'd0);
      chk("t6_order_err",         64'(order_err), 64'd0);
      n_obs = 0;
      step();
      chk("t6_idle_s_ready", 64'(last_rdy), 64'd0);
      chk("t6_idle_m_valid", 64'(m_valid),  64'd0);
      finish_pulse();
      run_until_done("t6", 20);
      chk("t6_count", 64'(n_obs), 64'd1);
      chk_obs("t6", 0, 28'd7, 0, 3);
      chk("t6_emit_final", 64'(emit_cnt), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
